// File: rtl/fp_control_unit_pkg.sv
// Shared definitions for the floating-point control unit: FSM state
// encoding, operation codes and datapath field widths.
package fp_control_unit_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 27;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_ROUND = 3'd4,
    ST_DONE  = 3'd5
  } fsmState_e;

endpackage

// File: rtl/fp_control_unit_exp_compare.sv
// Exponent comparison for operand alignment (purely combinational).
// Ports:
//   expDiff     in  two's-complement expA - expB
//   smallerIsB  out 1 when B has the smaller (or equal) exponent
//   absDiff     out |expDiff|, the right-shift amount for alignment
module fp_exp_compare
  import fp_control_unit_pkg::*;
(
  input  logic [EXP_W-1:0] expDiff,
  output logic             smallerIsB,
  output logic [EXP_W-1:0] absDiff
);

  logic signed [EXP_W-1:0] diffSigned;

  assign diffSigned = expDiff;
  assign smallerIsB = ~diffSigned[EXP_W-1];
  // Negating -128 wraps back to 8'h80, which read unsigned is exactly 128.
  assign absDiff    = diffSigned[EXP_W-1] ? $unsigned(-diffSigned)
                                          : $unsigned(diffSigned);

endmodule

// File: rtl/fp_control_unit.sv
// Control FSM sequencing one floating-point add/sub/mult through
// align -> big-ALU -> normalize -> round, with at most one renormalization.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, op          operation request (sampled only in IDLE)
//   expDiff            expA - expB from the small ALU
//   fracResult         fraction being normalized (bit 26 = overflow)
//   carry              big-ALU carry-out
//   smallerExpSrc      operand with the smaller exponent (0:A, 1:B)
//   shiftRightQtt      alignment shift amount
//   operation          op code driven to the big ALU
//   normalization_src  1: big-ALU result, 0: rounded result
//   shift_src          0: normalize left, 1: normalize right
//   busy, done, err    status; err is meaningful while done is high
module fp_control_unit
  import fp_control_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [EXP_W-1:0]  expDiff,
  input  logic [FRAC_W-1:0] fracResult,
  input  logic              carry,
  output logic              smallerExpSrc,
  output logic [EXP_W-1:0]  shiftRightQtt,
  output logic [1:0]        operation,
  output logic              normalization_src,
  output logic              shift_src,
  output logic              busy,
  output logic              done,
  output logic              err
);

  fsmState_e        state;
  fsmState_e        nextState;
  logic [1:0]       opReg;
  logic             renormFlag;
  logic             cmpSmallerIsB;
  logic [EXP_W-1:0] cmpAbsDiff;
  logic             overflow;
  logic             unusedFracBits;

  assign overflow       = fracResult[FRAC_W-1];
  assign unusedFracBits = ^fracResult[FRAC_W-2:0];

  fp_exp_compare uExpCompare (
    .expDiff    (expDiff),
    .smallerIsB (cmpSmallerIsB),
    .absDiff    (cmpAbsDiff)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      opReg         <= OP_ADD;
      renormFlag    <= 1'b0;
      smallerExpSrc <= 1'b0;
      shiftRightQtt <= '0;
      shift_src     <= 1'b0;
      err           <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        ST_IDLE: begin
          if (start) begin
            opReg      <= op;
            renormFlag <= 1'b0;
            err        <= (op == OP_RSVD);
          end
        end
        ST_ALIGN: begin
          smallerExpSrc <= cmpSmallerIsB;
          shiftRightQtt <= cmpAbsDiff;
        end
        ST_ADD: shift_src <= carry;
        ST_ROUND: begin
          // Rounding overflowed: one extra right-normalize pass.
          if (nextState == ST_NORM) begin
            renormFlag <= 1'b1;
            shift_src  <= 1'b1;
          end
        end
        ST_DONE: shift_src <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState         = state;
    operation         = OP_ADD;
    normalization_src = 1'b1;
    busy              = 1'b1;
    done              = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) nextState = (op == OP_RSVD) ? ST_DONE : ST_ALIGN;
      end
      ST_ALIGN: nextState = ST_ADD;
      ST_ADD: begin
        operation = opReg;
        nextState = ST_NORM;
      end
      ST_NORM: begin
        operation = opReg;
        // The renormalization pass works on the rounded value.
        normalization_src = ~renormFlag;
        nextState = ST_ROUND;
      end
      ST_ROUND: begin
        normalization_src = 1'b0;
        nextState = (overflow && !renormFlag) ? ST_NORM : ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_control_unit.sv
module tb_fp_control_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  expDiff;
  logic [26:0] fracResult;
  logic        carry;
  logic        smallerExpSrc;
  logic [7:0]  shiftRightQtt;
  logic [1:0]  operation;
  logic        normalization_src;
  logic        shift_src;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  fp_control_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .op                (op),
    .expDiff           (expDiff),
    .fracResult        (fracResult),
    .carry             (carry),
    .smallerExpSrc     (smallerExpSrc),
    .shiftRightQtt     (shiftRightQtt),
    .operation         (operation),
    .normalization_src (normalization_src),
    .shift_src         (shift_src),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] expDiff;
    logic       carry;
    logic       frac26;
    logic       hammer;
    logic       expSmaller;
    logic [7:0] expQtt;
    logic       expShiftSrc;
    int         expLat;
    logic       expErr;
    int         expNs0;
    int         expOpCyc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic runVec(input int idx, input vec_t v);
    int cyc;
    int busyCnt;
    int ns0Cnt;
    int opCnt;
    logic seenDone;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    start = 1'b1;
    op = v.op;
    expDiff = v.expDiff;
    carry = v.carry;
    fracResult = {v.frac26, 26'h2AAAAAA};
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    busyCnt = 0;
    ns0Cnt = 0;
    opCnt = 0;
    seenDone = 1'b0;
    while (cyc <= 20) begin
      if (busy) busyCnt++;
      if (!normalization_src) ns0Cnt++;
      if (operation == v.op) opCnt++;
      if (done) begin
        seenDone = 1'b1;
        start = 1'b0;
        break;
      end
      if (v.hammer) begin
        start = 1'b1;
        op = 2'b11;
      end
      @(posedge clk); #1;
      cyc++;
    end
    op = v.op;
    check({tag, " doneSeen"}, 32'(seenDone), 32'd1);
    check({tag, " latency"}, cyc, v.expLat);
    check({tag, " err"}, 32'(err), 32'(v.expErr));
    check({tag, " smallerExpSrc"}, 32'(smallerExpSrc), 32'(v.expSmaller));
    check({tag, " shiftRightQtt"}, 32'(shiftRightQtt), 32'(v.expQtt));
    check({tag, " shift_src"}, 32'(shift_src), 32'(v.expShiftSrc));
    check({tag, " busyCycles"}, busyCnt, v.expLat);
    check({tag, " normSrc0Cycles"}, ns0Cnt, v.expNs0);
    check({tag, " opCycles"}, opCnt, v.expOpCyc);
    @(posedge clk); #1;
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle done"}, 32'(done), 32'd0);
    check({tag, " idle operation"}, 32'(operation), 32'd0);
    check({tag, " idle normSrc"}, 32'(normalization_src), 32'd1);
    check({tag, " idle shift_src"}, 32'(shift_src), 32'd0);
    check({tag, " idle holdSmaller"}, 32'(smallerExpSrc), 32'(v.expSmaller));
    check({tag, " idle holdQtt"}, 32'(shiftRightQtt), 32'(v.expQtt));
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
    check({tag, " smallerExpSrc"}, 32'(smallerExpSrc), 32'd0);
    check({tag, " shiftRightQtt"}, 32'(shiftRightQtt), 32'd0);
    check({tag, " operation"}, 32'(operation), 32'd0);
    check({tag, " shift_src"}, 32'(shift_src), 32'd0);
    check({tag, " normSrc"}, 32'(normalization_src), 32'd1);
  endtask

  initial begin
    int doneCnt;
    int cyc;
    // op, expDiff, carry, frac26, hammer, smaller, qtt, shiftSrc, lat, err, ns0, opCyc
    vecs[0] = '{2'b00, 8'd3,   1'b0, 1'b0, 1'b0, 1'b1, 8'd3,   1'b0, 5, 1'b0, 1, 5};
    vecs[1] = '{2'b01, 8'hFB,  1'b1, 1'b0, 1'b0, 1'b0, 8'd5,   1'b1, 5, 1'b0, 1, 2};
    vecs[2] = '{2'b10, 8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 8'd0,   1'b1, 7, 1'b0, 3, 3};
    vecs[3] = '{2'b11, 8'h80,  1'b0, 1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 1, 1'b1, 0, 0};
    vecs[4] = '{2'b00, 8'h80,  1'b1, 1'b0, 1'b0, 1'b0, 8'd128, 1'b1, 5, 1'b0, 1, 5};
    vecs[5] = '{2'b01, 8'h7F,  1'b0, 1'b1, 1'b0, 1'b1, 8'd127, 1'b1, 7, 1'b0, 3, 3};
    vecs[6] = '{2'b00, 8'hFF,  1'b0, 1'b1, 1'b0, 1'b0, 8'd1,   1'b1, 7, 1'b0, 3, 7};
    vecs[7] = '{2'b01, 8'd2,   1'b0, 1'b0, 1'b1, 1'b1, 8'd2,   1'b0, 5, 1'b0, 1, 2};

    rst_n = 1'b0;
    start = 1'b0;
    op = 2'b00;
    expDiff = 8'd0;
    fracResult = '0;
    carry = 1'b0;
    #1;
    checkResetOutputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) runVec(i, vecs[i]);

    // Reset while in NORM: abort with no done pulse.
    @(negedge clk);
    start = 1'b1;
    op = 2'b01;
    expDiff = 8'd7;
    carry = 1'b1;
    fracResult = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midop operation", 32'(operation), 32'd1);
    check("midop shiftRightQtt", 32'(shiftRightQtt), 32'd7);
    check("midop shift_src", 32'(shift_src), 32'd1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    doneCnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) doneCnt++;
    end
    check("postrst doneCount", doneCnt, 0);
    check("postrst busy", 32'(busy), 32'd0);

    // First start accepted on the first edge after reset release.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    op = 2'b00;
    expDiff = 8'd4;
    carry = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("firstStart busy", 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc <= 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("firstStart latency", cyc, 5);
    check("firstStart qtt", 32'(shiftRightQtt), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
